// File: rtl/jelly_ram_singleport_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : jelly_ram_singleport_arbiter
//  Purpose  : Shares one single-port RAM between two valid/ready requesters
//             using a round-robin grant. Read data is routed back to the
//             issuing port after the RAM read latency (1 + DOUT_REGS).
//  Option   : JELLY_RAM_SINGLEPORT_ARBITER_WACK_EN - writes also produce an
//             rvalid completion pulse at the read latency.
//  Revision : 1.0 - initial release
// ============================================================================

module jelly_ram_singleport_arbiter #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int DOUT_REGS     = 0,
    parameter int PRIORITY_INIT = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic                  s0_we,
    input  logic [ADDR_WIDTH-1:0] s0_addr,
    input  logic [DATA_WIDTH-1:0] s0_wdata,
    output logic                  s0_rvalid,
    output logic [DATA_WIDTH-1:0] s0_rdata,

    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic                  s1_we,
    input  logic [ADDR_WIDTH-1:0] s1_addr,
    input  logic [DATA_WIDTH-1:0] s1_wdata,
    output logic                  s1_rvalid,
    output logic [DATA_WIDTH-1:0] s1_rdata,

    output logic                  ram_en,
    output logic                  ram_regcke,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    // Number of tracking stages equals the RAM read latency.
    localparam int   LATENCY        = 1 + DOUT_REGS;
    localparam logic PRIO_INIT_BIT  = (PRIORITY_INIT != 0);

    logic                  grant0;
    logic                  grant1;
    logic                  xfer;
    logic                  grant_port;
    logic                  grant_we;
    logic                  trk_in_vld;

    logic                  prio_q;
    logic                  prio_d;

    logic [LATENCY-1:0]    trk_vld_q;
    logic [LATENCY-1:0]    trk_port_q;
    logic                  resp_vld;
    logic                  resp_port;

    logic                  s0_rvalid_q;
    logic                  s1_rvalid_q;
    logic [DATA_WIDTH-1:0] s0_rdata_q;
    logic [DATA_WIDTH-1:0] s1_rdata_q;
    logic                  regcke_q;

    // Grant: a lone requester wins; on contention the priority pointer decides.
    // Nothing is granted while reset is asserted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n) begin
            if (s0_valid && s1_valid) begin
                if (prio_q) begin
                    grant1 = 1'b1;
                end else begin
                    grant0 = 1'b1;
                end
            end else if (s0_valid) begin
                grant0 = 1'b1;
            end else if (s1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign s0_ready   = grant0;
    assign s1_ready   = grant1;
    assign xfer       = grant0 | grant1;
    assign grant_port = grant1;

    // RAM pins follow the granted request; all zero when idle.
    always_comb begin
        grant_we = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (grant0) begin
            grant_we = s0_we;
            ram_addr = s0_addr;
            ram_din  = s0_wdata;
        end else if (grant1) begin
            grant_we = s1_we;
            ram_addr = s1_addr;
            ram_din  = s1_wdata;
        end
    end

    assign ram_en     = xfer;
    assign ram_we     = grant_we;
    assign ram_regcke = regcke_q;

`ifdef JELLY_RAM_SINGLEPORT_ARBITER_WACK_EN
    // Every accepted request is tracked so writes are acknowledged too.
    assign trk_in_vld = xfer;
`else
    // Only reads are tracked; writes complete silently.
    assign trk_in_vld = xfer & ~grant_we;
`endif

    // Next priority: hand the pointer to the port that lost this transfer.
    always_comb begin
        prio_d = prio_q;
        if (xfer) begin
            prio_d = ~grant_port;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prio_q <= PRIO_INIT_BIT;
        end else begin
            prio_q <= prio_d;
        end
    end

    // Output-register enable stays low in reset and high afterwards.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            regcke_q <= 1'b0;
        end else begin
            regcke_q <= 1'b1;
        end
    end

    // In-flight tag shift pipeline, aligned with the RAM read latency.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            trk_vld_q  <= '0;
            trk_port_q <= '0;
        end else begin
            trk_vld_q[0]  <= trk_in_vld;
            trk_port_q[0] <= grant_port;
            for (int i = 1; i < LATENCY; i++) begin
                trk_vld_q[i]  <= trk_vld_q[i-1];
                trk_port_q[i] <= trk_port_q[i-1];
            end
        end
    end

    assign resp_vld  = trk_vld_q[LATENCY-1];
    assign resp_port = trk_port_q[LATENCY-1];

    // Register the response onto the issuing port; rdata holds between pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s0_rvalid_q <= 1'b0;
            s1_rvalid_q <= 1'b0;
            s0_rdata_q  <= '0;
            s1_rdata_q  <= '0;
        end else begin
            s0_rvalid_q <= resp_vld & ~resp_port;
            s1_rvalid_q <= resp_vld &  resp_port;
            if (resp_vld && !resp_port) begin
                s0_rdata_q <= ram_dout;
            end
            if (resp_vld && resp_port) begin
                s1_rdata_q <= ram_dout;
            end
        end
    end

    assign s0_rvalid = s0_rvalid_q;
    assign s1_rvalid = s1_rvalid_q;
    assign s0_rdata  = s0_rdata_q;
    assign s1_rdata  = s1_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_jelly_ram_singleport_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jelly_ram_singleport_arbiter
//  Purpose  : Directed bench for jelly_ram_singleport_arbiter. Two instances
//             (DOUT_REGS = 0 and 1) share the same request stimulus, each with
//             its own WRITE_FIRST RAM model.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_jelly_ram_singleport_arbiter;

`ifdef JELLY_RAM_SINGLEPORT_ARBITER_WACK_EN
    localparam bit WACK = 1'b1;
`else
    localparam bit WACK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s0_valid, s0_we, s1_valid, s1_we;
    logic [7:0] s0_addr, s0_wdata, s1_addr, s1_wdata;

    logic       a_s0_ready, a_s0_rvalid, a_s1_ready, a_s1_rvalid;
    logic [7:0] a_s0_rdata, a_s1_rdata;
    logic       a_ram_en, a_ram_regcke, a_ram_we;
    logic [7:0] a_ram_addr, a_ram_din, a_ram_dout;

    logic       b_s0_ready, b_s0_rvalid, b_s1_ready, b_s1_rvalid;
    logic [7:0] b_s0_rdata, b_s1_rdata;
    logic       b_ram_en, b_ram_regcke, b_ram_we;
    logic [7:0] b_ram_addr, b_ram_din, b_ram_dout;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    jelly_ram_singleport_arbiter #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .DOUT_REGS(0), .PRIORITY_INIT(0)
    ) u_dut_a (
        .clk(clk), .reset_n(reset_n),
        .s0_valid(s0_valid), .s0_ready(a_s0_ready), .s0_we(s0_we),
        .s0_addr(s0_addr), .s0_wdata(s0_wdata),
        .s0_rvalid(a_s0_rvalid), .s0_rdata(a_s0_rdata),
        .s1_valid(s1_valid), .s1_ready(a_s1_ready), .s1_we(s1_we),
        .s1_addr(s1_addr), .s1_wdata(s1_wdata),
        .s1_rvalid(a_s1_rvalid), .s1_rdata(a_s1_rdata),
        .ram_en(a_ram_en), .ram_regcke(a_ram_regcke), .ram_we(a_ram_we),
        .ram_addr(a_ram_addr), .ram_din(a_ram_din), .ram_dout(a_ram_dout)
    );

    jelly_ram_singleport_arbiter #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .DOUT_REGS(1), .PRIORITY_INIT(0)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n),
        .s0_valid(s0_valid), .s0_ready(b_s0_ready), .s0_we(s0_we),
        .s0_addr(s0_addr), .s0_wdata(s0_wdata),
        .s0_rvalid(b_s0_rvalid), .s0_rdata(b_s0_rdata),
        .s1_valid(s1_valid), .s1_ready(b_s1_ready), .s1_we(s1_we),
        .s1_addr(s1_addr), .s1_wdata(s1_wdata),
        .s1_rvalid(b_s1_rvalid), .s1_rdata(b_s1_rdata),
        .ram_en(b_ram_en), .ram_regcke(b_ram_regcke), .ram_we(b_ram_we),
        .ram_addr(b_ram_addr), .ram_din(b_ram_din), .ram_dout(b_ram_dout)
    );

    // WRITE_FIRST single-port RAM, no output register.
    logic [7:0] mem_a [256];
    always @(posedge clk) begin
        if (a_ram_en) begin
            if (a_ram_we) begin
                mem_a[a_ram_addr] <= a_ram_din;
                a_ram_dout        <= a_ram_din;
            end else begin
                a_ram_dout <= mem_a[a_ram_addr];
            end
        end
    end

    // WRITE_FIRST single-port RAM with one output register stage.
    logic [7:0] mem_b [256];
    logic [7:0] b_dout_raw;
    always @(posedge clk) begin
        if (b_ram_en) begin
            if (b_ram_we) begin
                mem_b[b_ram_addr] <= b_ram_din;
                b_dout_raw        <= b_ram_din;
            end else begin
                b_dout_raw <= mem_b[b_ram_addr];
            end
        end
        if (b_ram_regcke) begin
            b_ram_dout <= b_dout_raw;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s0_valid = 1'b0; s0_we = 1'b0; s0_addr = 8'h00; s0_wdata = 8'h00;
        s1_valid = 1'b0; s1_we = 1'b0; s1_addr = 8'h00; s1_wdata = 8'h00;
    endtask

    task automatic drain(input int n);
        idle();
        for (int k = 0; k < n; k++) step();
    endtask

    int cnt_a0, cnt_a1, cnt_b0, cnt_b1;
    logic e_a0, e_a1, e_b0, e_b1;

    initial begin
        idle();
        reset_n  = 1'b0;
        s0_valid = 1'b1;
        step();
        step();
        // ---- reset state ----
        check_value("rst_s0_ready",  a_s0_ready,   0);
        check_value("rst_ram_en",    a_ram_en,     0);
        check_value("rst_ram_we",    a_ram_we,     0);
        check_value("rst_regcke_a",  a_ram_regcke, 0);
        check_value("rst_regcke_b",  b_ram_regcke, 0);
        check_value("rst_s0_rvalid", a_s0_rvalid,  0);
        check_value("rst_s1_rvalid", a_s1_rvalid,  0);
        check_value("rst_s0_rdata",  a_s0_rdata,   0);
        check_value("rst_s1_rdata",  a_s1_rdata,   0);
        s0_valid = 1'b0;
        reset_n  = 1'b1;
        step();
        check_value("regcke_on_a", a_ram_regcke, 1);
        check_value("regcke_on_b", b_ram_regcke, 1);

        // ---- write 0x5A @0x10 then read it back on port0 ----
        s0_valid = 1'b1; s0_we = 1'b1; s0_addr = 8'h10; s0_wdata = 8'h5A;
        #1;
        check_value("wr_s0_ready", a_s0_ready, 1);
        check_value("wr_s1_ready", a_s1_ready, 0);
        check_value("wr_ram_en",   a_ram_en,   1);
        check_value("wr_ram_we",   a_ram_we,   1);
        check_value("wr_ram_addr", a_ram_addr, 8'h10);
        check_value("wr_ram_din",  a_ram_din,  8'h5A);
        step();
        s0_we = 1'b0;
        #1;
        check_value("rd_ram_we", a_ram_we, 0);
        check_value("rd_ram_en", a_ram_en, 1);
        step();
        idle();
        check_value("t1_a_s0_rv_c2", a_s0_rvalid, WACK);
        check_value("t1_a_s0_rd_c2", a_s0_rdata,  WACK ? 8'h5A : 8'h00);
        check_value("t1_b_s0_rv_c2", b_s0_rvalid, 0);
        step();
        check_value("t1_a_s0_rv_c3", a_s0_rvalid, 1);
        check_value("t1_a_s0_rd_c3", a_s0_rdata,  8'h5A);
        check_value("t1_b_s0_rv_c3", b_s0_rvalid, WACK);
        check_value("t1_b_s0_rd_c3", b_s0_rdata,  WACK ? 8'h5A : 8'h00);
        check_value("t1_a_s1_rv_c3", a_s1_rvalid, 0);
        step();
        check_value("t1_a_s0_rv_c4", a_s0_rvalid, 0);
        check_value("t1_a_s0_hold",  a_s0_rdata,  8'h5A);
        check_value("t1_b_s0_rv_c4", b_s0_rvalid, 1);
        check_value("t1_b_s0_rd_c4", b_s0_rdata,  8'h5A);
        check_value("t1_a_s1_rv_c4", a_s1_rvalid, 0);
        check_value("t1_b_s1_rv_c4", b_s1_rvalid, 0);
        step();
        check_value("t1_b_s0_rv_c5", b_s0_rvalid, 0);

        // ---- preload 0x11 @0x01 (port0) and 0x22 @0x02 (port1) ----
        s0_valid = 1'b1; s0_we = 1'b1; s0_addr = 8'h01; s0_wdata = 8'h11;
        step();
        idle();
        s1_valid = 1'b1; s1_we = 1'b1; s1_addr = 8'h02; s1_wdata = 8'h22;
        step();
        drain(3);

        // ---- continuous contention: grants alternate 0,1,0,1,0,1 ----
        cnt_a0 = 0; cnt_a1 = 0; cnt_b0 = 0; cnt_b1 = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 6) begin
                s0_valid = 1'b1; s0_we = 1'b0; s0_addr = 8'h01;
                s1_valid = 1'b1; s1_we = 1'b0; s1_addr = 8'h02;
            end else begin
                idle();
            end
            #1;
            if (i < 6) begin
                check_value($sformatf("cont_s0_ready_%0d", i), a_s0_ready, (i % 2 == 0));
                check_value($sformatf("cont_s1_ready_%0d", i), a_s1_ready, (i % 2 == 1));
                check_value($sformatf("cont_addr_%0d", i), a_ram_addr, (i % 2 == 0) ? 8'h01 : 8'h02);
            end
            e_a0 = (i == 2 || i == 4 || i == 6);
            e_a1 = (i == 3 || i == 5 || i == 7);
            e_b0 = (i == 3 || i == 5 || i == 7);
            e_b1 = (i == 4 || i == 6 || i == 8);
            check_value($sformatf("cont_a_s0_rv_%0d", i), a_s0_rvalid, e_a0);
            check_value($sformatf("cont_a_s1_rv_%0d", i), a_s1_rvalid, e_a1);
            check_value($sformatf("cont_b_s0_rv_%0d", i), b_s0_rvalid, e_b0);
            check_value($sformatf("cont_b_s1_rv_%0d", i), b_s1_rvalid, e_b1);
            if (e_a0) check_value($sformatf("cont_a_s0_rd_%0d", i), a_s0_rdata, 8'h11);
            if (e_a1) check_value($sformatf("cont_a_s1_rd_%0d", i), a_s1_rdata, 8'h22);
            if (e_b0) check_value($sformatf("cont_b_s0_rd_%0d", i), b_s0_rdata, 8'h11);
            if (e_b1) check_value($sformatf("cont_b_s1_rd_%0d", i), b_s1_rdata, 8'h22);
            cnt_a0 += int'(a_s0_rvalid); cnt_a1 += int'(a_s1_rvalid);
            cnt_b0 += int'(b_s0_rvalid); cnt_b1 += int'(b_s1_rvalid);
            step();
        end
        check_value("cont_cnt_a0", cnt_a0, 3);
        check_value("cont_cnt_a1", cnt_a1, 3);
        check_value("cont_cnt_b0", cnt_b0, 3);
        check_value("cont_cnt_b1", cnt_b1, 3);

        // ---- port1 preload 0xA0..0xA3 @0x20..0x23, then back-to-back reads ----
        for (int i = 0; i < 4; i++) begin
            idle();
            s1_valid = 1'b1; s1_we = 1'b1;
            s1_addr = 8'h20 + 8'(i); s1_wdata = 8'hA0 + 8'(i);
            step();
        end
        drain(4);
        for (int i = 0; i < 8; i++) begin
            idle();
            if (i < 4) begin
                s1_valid = 1'b1; s1_addr = 8'h20 + 8'(i);
            end
            #1;
            if (i < 4) begin
                check_value($sformatf("b2b_s1_ready_%0d", i), a_s1_ready, 1);
            end
            e_a1 = (i >= 2 && i <= 5);
            e_b1 = (i >= 3 && i <= 6);
            check_value($sformatf("b2b_a_s1_rv_%0d", i), a_s1_rvalid, e_a1);
            check_value($sformatf("b2b_b_s1_rv_%0d", i), b_s1_rvalid, e_b1);
            if (e_a1) check_value($sformatf("b2b_a_s1_rd_%0d", i), a_s1_rdata, 8'hA0 + 8'(i - 2));
            if (e_b1) check_value($sformatf("b2b_b_s1_rd_%0d", i), b_s1_rdata, 8'hA0 + 8'(i - 3));
            step();
        end

        // ---- reset while a port0 read is in flight ----
        s0_valid = 1'b1; s0_we = 1'b0; s0_addr = 8'h10;
        step();
        reset_n  = 1'b0;
        s0_valid = 1'b1; s1_valid = 1'b1; s0_addr = 8'h10; s1_addr = 8'h02;
        #1;
        check_value("mrst_s0_ready", a_s0_ready, 0);
        check_value("mrst_s1_ready", a_s1_ready, 0);
        check_value("mrst_ram_en",   a_ram_en,   0);
        step();
        idle();
        reset_n = 1'b1;
        check_value("mrst_a_s0_rv_1", a_s0_rvalid, 0);
        check_value("mrst_a_s0_rd",   a_s0_rdata,  0);
        step();
        check_value("mrst_a_s0_rv_2", a_s0_rvalid, 0);
        check_value("mrst_b_s0_rv_2", b_s0_rvalid, 0);
        step();
        check_value("mrst_b_s0_rv_3", b_s0_rvalid, 0);
        s0_valid = 1'b1; s0_addr = 8'h01;
        s1_valid = 1'b1; s1_addr = 8'h02;
        #1;
        check_value("mrst_prio_s0", a_s0_ready, 1);
        check_value("mrst_prio_s1", a_s1_ready, 0);
        step();
        drain(4);

        // ---- port1 write 0x33 @0x05: acknowledge only with WACK ----
        s1_valid = 1'b1; s1_we = 1'b1; s1_addr = 8'h05; s1_wdata = 8'h33;
        step();
        idle();
        check_value("wack_a_rv_1", a_s1_rvalid, 0);
        step();
        check_value("wack_a_rv_2", a_s1_rvalid, WACK);
        check_value("wack_a_rd_2", a_s1_rdata,  WACK ? 8'h33 : 8'h00);
        step();
        check_value("wack_a_rv_3", a_s1_rvalid, 0);
        check_value("wack_b_rv_3", b_s1_rvalid, WACK);
        check_value("wack_b_rd_3", b_s1_rdata,  WACK ? 8'h33 : 8'h00);
        step();
        check_value("wack_b_rv_4", b_s1_rvalid, 0);
        s1_valid = 1'b1; s1_addr = 8'h05;
        step();
        idle();
        step();
        check_value("wack_rb_rv", a_s1_rvalid, 1);
        check_value("wack_rb_rd", a_s1_rdata,  8'h33);
        drain(3);

        // ---- port0 alone for 4 cycles, then contention favours port1 ----
        for (int i = 0; i < 4; i++) begin
            s0_valid = 1'b1; s0_we = 1'b0; s0_addr = 8'h30 + 8'(i);
            #1;
            check_value($sformatf("solo_s0_ready_%0d", i), a_s0_ready, 1);
            check_value($sformatf("solo_ram_en_%0d", i),   a_ram_en,   1);
            step();
        end
        drain(4);
        s0_addr = 8'hFF; s0_wdata = 8'hEE;
        #1;
        check_value("idle_ram_addr", a_ram_addr, 8'h00);
        check_value("idle_ram_din",  a_ram_din,  8'h00);
        check_value("idle_ram_en",   a_ram_en,   0);
        s0_valid = 1'b1; s0_addr = 8'h01;
        s1_valid = 1'b1; s1_addr = 8'h02;
        #1;
        check_value("solo_prio_s1", a_s1_ready, 1);
        check_value("solo_prio_s0", a_s0_ready, 0);
        check_value("solo_prio_addr", a_ram_addr, 8'h02);
        step();
        drain(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/jelly_ram_singleport_arbiter.md
Name: jelly_ram_singleport_arbiter

Overview:
- Shares one single-port RAM between two requester ports (s0, s1), each using a valid/ready request handshake.
- Round-robin arbiter issues at most one RAM access per cycle and drives the RAM's en/regcke/we/addr/din pins.
- Tracks in-flight reads and returns read data to the issuing port after the RAM's fixed read latency.
- Sits between two bus masters (e.g. a CPU data port and a DMA engine) and a RAM instance configured with the same DOUT_REGS value.

Parameters:
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- DOUT_REGS, 0, must match the RAM; read latency = 1 + DOUT_REGS (1 or 2 cycles).
- PRIORITY_INIT, 0, port given priority after reset (0 or 1).

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- s0_valid  input  1  port0 request valid
- s0_ready  output  1  port0 request accepted this cycle
- s0_we  input  1  1 = write, 0 = read
- s0_addr  input  ADDR_WIDTH  port0 address
- s0_wdata  input  DATA_WIDTH  port0 write data
- s0_rvalid  output  1  port0 read data valid (1-cycle pulse)
- s0_rdata  output  DATA_WIDTH  port0 read data
- s1_valid, s1_ready, s1_we, s1_addr, s1_wdata, s1_rvalid, s1_rdata: same widths and meanings for port1
- ram_en  output  1  RAM enable
- ram_regcke  output  1  RAM output-register clock enable
- ram_we  output  1  RAM write enable
- ram_addr  output  ADDR_WIDTH  RAM address
- ram_din  output  DATA_WIDTH  RAM write data
- ram_dout  input  DATA_WIDTH  RAM read data

Behaviour:
- Clock is clk. Reset is reset_n: synchronous, active-low, sampled on posedge clk.
- Reset values:
  - s*_ready is 0 while reset_n = 0. s*_rvalid = 0, s*_rdata = 0.
  - ram_en = 0, ram_we = 0. ram_regcke = 0.
  - Priority pointer = PRIORITY_INIT. All in-flight tag pipeline stages cleared.
- Grant (combinational, same cycle):
  - Only s0_valid asserted -> grant port0. Only s1_valid asserted -> grant port1.
  - Both asserted -> grant the port selected by the priority pointer.
  - sN_ready = grant to port N. A transfer occurs when valid && ready.
  - ready depends on valid. Requesters must not make valid depend on ready.
- Priority pointer: updated on each transfer to the non-granted port. It holds when there is no transfer.
- RAM drive (combinational from the grant):
  - ram_en = any transfer. ram_we = granted we.
  - ram_addr / ram_din = granted addr / wdata. When idle, these hold 0.
- ram_regcke is held at 1 out of reset, so the output register always advances.
- Read tracking: a shift pipeline of depth 1+DOUT_REGS carries {valid, port} for each accepted read. Writes enter as invalid.
- Read response: when the last stage is valid, the matching sN_rvalid is registered high for exactly one cycle and sN_rdata <= ram_dout.
  - Read latency is 2+DOUT_REGS cycles from the accepting clock edge to the rvalid-high cycle.
- Responses have no backpressure. Ports must always accept rvalid.
- Back-to-back accesses: one per cycle with no bubble. Alternating grants under continuous contention give 50/50 throughput.
- Same-address write then read on consecutive cycles returns the new data; the RAM is WRITE_FIRST or READ_FIRST, but the write commits before the next read.
- Reset mid-operation: in-flight reads are discarded and no rvalid is produced for them. The pointer returns to PRIORITY_INIT.
- sN_rdata holds its last value between pulses.

Optional Feature:
- Macro: JELLY_RAM_SINGLEPORT_ARBITER_WACK_EN.
- Defined:
  - Writes also enter the tracking pipeline as valid.
  - The issuing port gets sN_rvalid pulsed at the same latency as a read, with sN_rdata = ram_dout. This equals the written data with a WRITE_FIRST RAM.
  - Gives every request a completion acknowledge.
- Undefined: writes produce no response. Only reads pulse rvalid.

Test Plan:
- Port0 writes 0x5A to addr 0x10, then reads addr 0x10 (DOUT_REGS=0) -> s0_rvalid pulses 2 cycles after read acceptance with s0_rdata=0x5A. s1_rvalid stays 0.
- Both ports hold valid reads for 6 cycles (addr 0x01 / 0x02, PRIORITY_INIT=0) -> grants alternate 0,1,0,1,0,1. Each port gets 3 rvalid pulses with correct data.
- DOUT_REGS=1, port1 issues back-to-back reads of 0x20..0x23 preloaded 0xA0..0xA3 -> s1_rvalid high 4 consecutive cycles starting 3 cycles after the first acceptance, data 0xA0..0xA3 in order.
- Port0 read issued, then reset_n=0 for 1 cycle before the response -> no rvalid pulse. ram_en=0 during reset. The next contention grants port PRIORITY_INIT.
- WACK_EN defined, port1 writes 0x33 to addr 0x05 -> s1_rvalid pulses at read latency with s1_rdata=0x33. Undefined -> no pulse.
- Port0 valid only, s1 idle for 4 cycles -> s0_ready=1 every cycle, 4 transfers, pointer ends favouring port1.
